program_loader: RTL and testbench

Boot-time writer for the CPU's 16-bit instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit words, and writes them to consecutive instruction addresses starting at 0. It holds the CPU (PC and state sequencer) while loading and releases it once the program is in place. It sits between the external byte source and the instruction memory's write port, on the same clock as the CPU.

---
 rtl/program_loader_if.sv | 44 ++++
 rtl/program_loader.sv | 184 ++++++++++++++++++
 tb/tb_program_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bus for the boot-time program loader.
// The master modport is the loader itself; the slave modport is the byte
// source / memory / CPU-control side of the same wires.
interface program_loader_if;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] loaded_count;

    modport master (
        input  start,
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_data,
        output cpu_hold,
        output done,
        output error,
        output loaded_count
    );

    modport slave (
        output start,
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_data,
        input  cpu_hold,
        input  done,
        input  error,
        input  loaded_count
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time writer for the CPU's 16-bit instruction memory.
// Receives a length-prefixed, big-endian byte stream, writes the words to
// consecutive addresses from 0, and holds the CPU until the load is complete.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to append and verify a
// 16-bit wrapping checksum of all written words after the last word.
module program_loader #(
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.master bus
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
        S_WRITE, S_CSUM_HI, S_CSUM_LO, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
        S_WRITE, S_DONE, S_ERR
    } state_t;
`endif

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t      r_state;
    state_t      w_nextState;

    logic [7:0]  r_lenHi;
    logic [15:0] r_len;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic [15:0] r_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [15:0] r_sum;
    logic [7:0]  r_csumHi;
    logic [15:0] w_csumRx;
`endif

    logic        w_byteReady;
    logic        w_xfer;
    logic        w_startOk;
    logic [15:0] w_lenN;
    logic        w_lenBad;
    logic [15:0] w_countNext;
    logic        w_moreWords;
    logic [15:0] w_word;

    assign w_xfer      = bus.byte_valid && w_byteReady;
    assign w_startOk   = bus.start &&
                         (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_lenN      = {r_lenHi, bus.byte_in};
    assign w_lenBad    = (w_lenN == 16'd0) || (w_lenN > DEPTH_W);
    assign w_countNext = r_count + 16'd1;
    assign w_moreWords = w_countNext < r_len;
    assign w_word      = {r_hi, r_lo};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign w_csumRx    = {r_csumHi, bus.byte_in};
`endif

    // State register; reset abandons any load in progress immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: byte states advance only on an accepted transfer, WRITE is one cycle.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_startOk) w_nextState = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) w_nextState = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_xfer) w_nextState = w_lenBad ? S_ERR : S_DATA_HI;
            end
            S_DATA_HI: begin
                if (w_xfer) w_nextState = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (w_xfer) w_nextState = S_WRITE;
            end
            S_WRITE: begin
                if (w_moreWords) begin
                    w_nextState = S_DATA_HI;
                end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    w_nextState = S_CSUM_HI;
`else
                    w_nextState = S_DONE;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM_HI: begin
                if (w_xfer) w_nextState = S_CSUM_LO;
            end
            S_CSUM_LO: begin
                if (w_xfer) w_nextState = (w_csumRx == r_sum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                if (w_startOk) w_nextState = S_LEN_HI;
            end
            S_ERR: begin
                if (w_startOk) w_nextState = S_LEN_HI;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Ready is offered only in states that consume a stream byte.
    always_comb begin
        w_byteReady = 1'b0;
        case (r_state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: w_byteReady = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM_HI, S_CSUM_LO:                     w_byteReady = 1'b1;
`endif
            default:                                  w_byteReady = 1'b0;
        endcase
    end

    // Datapath: capture length and word bytes, count written words, and track the running sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lenHi  <= 8'd0;
            r_len    <= 16'd0;
            r_hi     <= 8'd0;
            r_lo     <= 8'd0;
            r_count  <= 16'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_sum    <= 16'd0;
            r_csumHi <= 8'd0;
`endif
        end else begin
            if (w_startOk) begin
                r_count <= 16'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                r_sum   <= 16'd0;
`endif
            end
            case (r_state)
                S_LEN_HI:  if (w_xfer) r_lenHi <= bus.byte_in;
                S_LEN_LO:  if (w_xfer) r_len   <= w_lenN;
                S_DATA_HI: if (w_xfer) r_hi    <= bus.byte_in;
                S_DATA_LO: if (w_xfer) r_lo    <= bus.byte_in;
                S_WRITE: begin
                    r_count <= w_countNext;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    r_sum   <= r_sum + w_word;
`endif
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CSUM_HI: if (w_xfer) r_csumHi <= bus.byte_in;
`endif
                default: begin
                end
            endcase
        end
    end

    // Address and data are gated to the write cycle so the bus never shows
    // the post-load count, which can equal DEPTH.
    assign bus.byte_ready   = w_byteReady;
    assign bus.imem_we      = (r_state == S_WRITE);
    assign bus.imem_addr    = (r_state == S_WRITE) ? r_count : 16'd0;
    assign bus.imem_data    = (r_state == S_WRITE) ? w_word  : 16'd0;
    assign bus.cpu_hold     = !(r_state == S_IDLE || r_state == S_DONE);
    assign bus.done         = (r_state == S_DONE);
    assign bus.error        = (r_state == S_ERR);
    assign bus.loaded_count = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
// Inputs change 1 ns after the rising edge; a negedge monitor records every
// memory write into a local model of the instruction memory.
module tb_program_loader;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   weCount;
    logic [15:0] memModel [0:63];

    program_loader_if bus ();

    program_loader #(.DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record each write strobe and check it never leaves the memory range.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            weCount = weCount + 1;
            checks  = checks + 1;
            if (bus.imem_addr >= 16'd64) begin
                errors = errors + 1;
                $display("[TB] FAIL addr_bound: got %h, expected below 0040", bus.imem_addr);
            end else begin
                memModel[bus.imem_addr[5:0]] = bus.imem_data;
            end
        end
    end

    task automatic pulseStart();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Offer one byte, wait for it to be accepted, then idle for stall cycles.
    task automatic sendByte(input logic [7:0] b, input int stall);
        int guard;
        guard = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        @(negedge clk);
        while (bus.byte_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte_timeout: byte %h never accepted, expected ready within 50 cycles", b);
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        repeat (stall) begin
            @(posedge clk); #1;
        end
    endtask

    // Close a frame after the last WRITE: send the checksum if enabled, else wait one edge.
    task automatic finishFrame(input logic [15:0] csum);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sendByte(csum[15:8], 0);
        sendByte(csum[7:0], 0);
`else
        if (csum === 16'hxxxx) $display("[TB] note: undefined checksum argument");
        @(posedge clk); #1;
`endif
    endtask

    task automatic checkResetOutputs(input string tag);
        checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL %s byte_ready: got %b, expected 0", tag, bus.byte_ready); end
        checks++; if (bus.imem_we !== 1'b0) begin errors++; $display("[TB] FAIL %s imem_we: got %b, expected 0", tag, bus.imem_we); end
        checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL %s cpu_hold: got %b, expected 0", tag, bus.cpu_hold); end
        checks++; if (bus.done !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("[TB] FAIL %s done/error: got %b%b, expected 00", tag, bus.done, bus.error); end
        checks++; if (bus.imem_addr !== 16'd0 || bus.imem_data !== 16'd0) begin errors++; $display("[TB] FAIL %s addr/data: got %h/%h, expected 0000/0000", tag, bus.imem_addr, bus.imem_data); end
        checks++; if (bus.loaded_count !== 16'd0) begin errors++; $display("[TB] FAIL %s loaded_count: got %0d, expected 0", tag, bus.loaded_count); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic runBasic(input string tag, input int stall);
        weCount = 0;
        pulseStart();
        checks++; if (bus.cpu_hold !== 1'b1 || bus.byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s hold_ready: got %b%b, expected 11", tag, bus.cpu_hold, bus.byte_ready); end
        sendByte(8'h00, stall);
        sendByte(8'h02, stall);
        sendByte(8'h12, stall);
        sendByte(8'h34, stall);
        sendByte(8'hAB, stall);
        sendByte(8'hCD, 0);
        checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 16'd1 || bus.imem_data !== 16'hABCD) begin errors++; $display("[TB] FAIL %s last_write: got we=%b %h=%h, expected we=1 0001=abcd", tag, bus.imem_we, bus.imem_addr, bus.imem_data); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL %s done_early: got %b, expected 0", tag, bus.done); end
        finishFrame(16'hBE01);
        checks++; if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("[TB] FAIL %s done_hold_err: got %b%b%b, expected 100", tag, bus.done, bus.cpu_hold, bus.error); end
        checks++; if (bus.loaded_count !== 16'd2) begin errors++; $display("[TB] FAIL %s loaded_count: got %0d, expected 2", tag, bus.loaded_count); end
        checks++; if (memModel[0] !== 16'h1234 || memModel[1] !== 16'hABCD) begin errors++; $display("[TB] FAIL %s mem: got %h %h, expected 1234 abcd", tag, memModel[0], memModel[1]); end
        checks++; if (weCount !== 2) begin errors++; $display("[TB] FAIL %s we_pulses: got %0d, expected 2", tag, weCount); end
    endtask

    task automatic test_basic();
        runBasic("basic", 0);
    endtask

    task automatic test_stalls();
        memModel[0] = 16'h0000;
        memModel[1] = 16'h0000;
        runBasic("stalls", 3);
    endtask

    task automatic test_bad_length();
        weCount = 0;
        pulseStart();
        checks++; if (bus.done !== 1'b0 || bus.loaded_count !== 16'd0) begin errors++; $display("[TB] FAIL restart_clear: got done=%b count=%0d, expected done=0 count=0", bus.done, bus.loaded_count); end
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        checks++; if (bus.error !== 1'b1 || bus.cpu_hold !== 1'b1) begin errors++; $display("[TB] FAIL len_zero: got err=%b hold=%b, expected 1 1", bus.error, bus.cpu_hold); end
        pulseStart();
        checks++; if (bus.error !== 1'b0 || bus.byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL err_restart: got err=%b ready=%b, expected 0 1", bus.error, bus.byte_ready); end
        sendByte(8'h00, 0);
        sendByte(8'h41, 0);
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (bus.error !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("[TB] FAIL len_65: got err=%b hold=%b done=%b, expected 1 1 0", bus.error, bus.cpu_hold, bus.done); end
        checks++; if (weCount !== 0) begin errors++; $display("[TB] FAIL bad_len_we: got %0d, expected 0", weCount); end
    endtask

    task automatic test_full_depth();
        weCount = 0;
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h40, 0);
        for (int i = 0; i < 64; i++) begin
            sendByte(8'h00, 0);
            sendByte(8'(i), 0);
        end
        checks++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 16'd63 || bus.imem_data !== 16'h003F) begin errors++; $display("[TB] FAIL full_last: got we=%b %h=%h, expected we=1 003f=003f", bus.imem_we, bus.imem_addr, bus.imem_data); end
        finishFrame(16'h07E0);
        checks++; if (bus.done !== 1'b1 || bus.loaded_count !== 16'd64) begin errors++; $display("[TB] FAIL full_done: got done=%b count=%0d, expected 1 64", bus.done, bus.loaded_count); end
        checks++; if (weCount !== 64 || memModel[10] !== 16'h000A || memModel[63] !== 16'h003F) begin errors++; $display("[TB] FAIL full_mem: got we=%0d m10=%h m63=%h, expected 64 000a 003f", weCount, memModel[10], memModel[63]); end
        checks++; if (bus.imem_addr !== 16'd0) begin errors++; $display("[TB] FAIL full_idle_addr: got %h, expected 0000", bus.imem_addr); end
    endtask

    task automatic test_mid_reset();
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h03, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        @(posedge clk); #1;
        checks++; if (bus.loaded_count !== 16'd1 || bus.byte_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_count: got count=%0d ready=%b, expected 1 1", bus.loaded_count, bus.byte_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
        checkResetOutputs("mid_reset");
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        weCount = 0;
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        sendByte(8'h55, 0);
        pulseStart();
        checks++; if (bus.byte_ready !== 1'b1 || bus.loaded_count !== 16'd0) begin errors++; $display("[TB] FAIL busy_start: got ready=%b count=%0d, expected 1 0", bus.byte_ready, bus.loaded_count); end
        sendByte(8'h66, 0);
        sendByte(8'h77, 0);
        sendByte(8'h88, 0);
        finishFrame(16'hCCEE);
        checks++; if (bus.done !== 1'b1 || bus.loaded_count !== 16'd2 || weCount !== 2) begin errors++; $display("[TB] FAIL busy_done: got done=%b count=%0d we=%0d, expected 1 2 2", bus.done, bus.loaded_count, weCount); end
        checks++; if (memModel[0] !== 16'h5566 || memModel[1] !== 16'h7788) begin errors++; $display("[TB] FAIL busy_mem: got %h %h, expected 5566 7788", memModel[0], memModel[1]); end
    endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        weCount = 0;
        pulseStart();
        sendByte(8'h00, 0); sendByte(8'h02, 0);
        sendByte(8'h00, 0); sendByte(8'h01, 0);
        sendByte(8'h00, 0); sendByte(8'h02, 0);
        sendByte(8'h00, 0); sendByte(8'h03, 0);
        checks++; if (bus.done !== 1'b1 || bus.error !== 1'b0) begin errors++; $display("[TB] FAIL csum_good: got done=%b err=%b, expected 1 0", bus.done, bus.error); end
        weCount = 0;
        pulseStart();
        sendByte(8'h00, 0); sendByte(8'h02, 0);
        sendByte(8'h00, 0); sendByte(8'h01, 0);
        sendByte(8'h00, 0); sendByte(8'h02, 0);
        sendByte(8'h00, 0); sendByte(8'h04, 0);
        checks++; if (bus.error !== 1'b1 || bus.cpu_hold !== 1'b1 || weCount !== 2) begin errors++; $display("[TB] FAIL csum_bad: got err=%b hold=%b we=%0d, expected 1 1 2", bus.error, bus.cpu_hold, weCount); end
    endtask
`endif

    // Run every scenario in sequence, then report.
    initial begin
        checks         = 0;
        errors         = 0;
        weCount        = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        for (int i = 0; i < 64; i++) memModel[i] = 16'h0000;
        test_reset();
        test_basic();
        test_stalls();
        test_bad_length();
        test_full_depth();
        test_mid_reset();
        test_start_ignored();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
